// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int LANE_WIDTH  = 32;
    localparam int BEAT_STRIDE = 4;

endpackage

// File: rtl/pipe_memory_access_vp.sv
// M-stage load/store unit: splits scalar/vector accesses into 32-bit req/gnt/rvalid beats.
// Min latency 4 cycles scalar load, 1+2*LANES+1 vector load; stall_M held until DONE, gnt/rvalid stretch it.
module pipe_memory_access_vp
    import mem_access_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        async_reset,
    input  logic                        mem_read_M,
    input  logic                        mem_write_M,
    input  logic                        vector_op_M,
    input  logic [LANES*LANE_WIDTH-1:0] ALU_result_bus_M,
    input  logic [LANES*LANE_WIDTH-1:0] write_data_bus_M,
    input  logic                        pipeline_hold,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [LANE_WIDTH-1:0]       mem_wdata,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [LANE_WIDTH-1:0]       mem_rdata,
    output logic [LANES*LANE_WIDTH-1:0] read_data_bus_M,
    output logic                        stall_M
);

    localparam int BUS_W  = LANES * LANE_WIDTH;
    localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BEAT_W-1:0] LAST_VEC_BEAT = BEAT_W'(LANES - 1);

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [BUS_W-1:0]        wbuf_q, wbuf_d;
    logic [BUS_W-1:0]        data_q, data_d;
    logic                    vec_q, vec_d;
    logic                    we_q, we_d;

    logic                    op;
    logic                    last_beat;
    logic                    req_d;
    logic                    we_out_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [LANE_WIDTH-1:0]   wdata_d;

    logic addr_bits_unused;
    assign addr_bits_unused = ^{ALU_result_bus_M[BUS_W-1:ADDR_WIDTH], ALU_result_bus_M[1:0]};

    assign op        = mem_read_M | mem_write_M;
    assign last_beat = vec_q ? (beat_q == LAST_VEC_BEAT) : (beat_q == '0);

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            wbuf_q  <= '0;
            data_q  <= '0;
            vec_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            wbuf_q  <= wbuf_d;
            data_q  <= data_d;
            vec_q   <= vec_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        wbuf_d  = wbuf_q;
        data_d  = data_q;
        vec_d   = vec_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (op) begin
                    base_d  = {ALU_result_bus_M[ADDR_WIDTH-1:2], 2'b00};
                    wbuf_d  = write_data_bus_M;
                    vec_d   = vector_op_M;
                    we_d    = mem_write_M;
                    beat_d  = '0;
                    data_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    if (!we_q) begin
                        state_d = WAIT_R;
                    end else if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    data_d[int'(beat_q)*LANE_WIDTH +: LANE_WIDTH] = mem_rdata;
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                // Holding here keeps a stalled instruction from being issued twice.
                if (!pipeline_hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_M = 1'b0;
        case (state_q)
            IDLE:          stall_M = op;
            ISSUE, WAIT_R: stall_M = 1'b1;
            default:       stall_M = 1'b0;
        endcase
        // Reset also releases the pipeline freeze, even if an op is still presented.
        stall_M = stall_M & async_reset;

        req_d    = (state_d == ISSUE);
        we_out_d = req_d & we_d;
        addr_d   = req_d ? (base_d + ADDR_WIDTH'(beat_d) * ADDR_WIDTH'(BEAT_STRIDE)) : '0;
        wdata_d  = we_out_d ? wbuf_d[int'(beat_d)*LANE_WIDTH +: LANE_WIDTH] : '0;
    end

    // Beat port is registered from next-state values so it is valid in the first ISSUE cycle.
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req   <= req_d;
            mem_we    <= we_out_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

    assign read_data_bus_M = data_q;

endmodule

// File: tb/tb_pipe_memory_access_vp.sv
// Directed bench for pipe_memory_access_vp: scalar vector table plus multi-cycle corner sequences.
module tb_pipe_memory_access_vp;

    logic         clock;
    logic         async_reset;
    logic         mem_read_M;
    logic         mem_write_M;
    logic         vector_op_M;
    logic [127:0] ALU_result_bus_M;
    logic [127:0] write_data_bus_M;
    logic         pipeline_hold;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic [127:0] read_data_bus_M;
    logic         stall_M;

    pipe_memory_access_vp #(.LANES(4), .ADDR_WIDTH(32)) dut (
        .clock            (clock),
        .async_reset      (async_reset),
        .mem_read_M       (mem_read_M),
        .mem_write_M      (mem_write_M),
        .vector_op_M      (vector_op_M),
        .ALU_result_bus_M (ALU_result_bus_M),
        .write_data_bus_M (write_data_bus_M),
        .pipeline_hold    (pipeline_hold),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .read_data_bus_M  (read_data_bus_M),
        .stall_M          (stall_M)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] cap_addr  [4];
    logic [31:0] cap_wdata [4];
    logic        cap_we    [4];
    int          n_beats;
    int          n_stall;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wd;
        logic [31:0]  rd;
        logic [31:0]  exp_addr;
        logic [127:0] exp_rdb;
        int           exp_stall;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        @(negedge clock);
        mem_read_M  = 1'b0;
        mem_write_M = 1'b0;
        vector_op_M = 1'b0;
    endtask

    // Memory responder: grants each request (optionally delaying one beat), returns rvalid the cycle after gnt.
    // Returns at negedge+1 of the first cycle with stall_M low (DONE), with ops still presented.
    task automatic do_access(input logic wr, input logic vec, input logic [31:0] addr,
                             input logic [127:0] wd, input logic [127:0] rd,
                             input int wait_beat, input int wait_cyc);
        int          cyc;
        int          gnt_wait;
        int          rv_beat;
        logic        rv_pend;
        logic        done;
        logic [31:0] w_addr;
        logic [31:0] w_data;
        cyc = 0; gnt_wait = 0; rv_beat = 0; rv_pend = 1'b0; done = 1'b0;
        w_addr = '0; w_data = '0;
        n_beats = 0; n_stall = 0;
        for (int i = 0; i < 4; i++) begin
            cap_addr[i] = 'x; cap_wdata[i] = 'x; cap_we[i] = 1'bx;
        end
        @(negedge clock);
        mem_read_M       = !wr;
        mem_write_M      = wr;
        vector_op_M      = vec;
        ALU_result_bus_M = {96'h0, addr};
        write_data_bus_M = wd;
        mem_gnt          = 1'b0;
        mem_rvalid       = 1'b0;
        #1;
        if (stall_M) n_stall++;
        do begin
            @(negedge clock);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd[rv_beat*32 +: 32];
                rv_pend    = 1'b0;
            end
            #1;
            if (!stall_M) begin
                done = 1'b1;
            end else begin
                n_stall++;
                if (mem_req) begin
                    if (n_beats == wait_beat && gnt_wait < wait_cyc) begin
                        if (gnt_wait == 0) begin
                            w_addr = mem_addr;
                            w_data = mem_wdata;
                        end else begin
                            check("wait_addr_stable", mem_addr, w_addr);
                            check("wait_wdata_stable", mem_wdata, w_data);
                        end
                        gnt_wait++;
                    end else begin
                        mem_gnt = 1'b1;
                        if (n_beats < 4) begin
                            cap_addr[n_beats]  = mem_addr;
                            cap_wdata[n_beats] = mem_wdata;
                            cap_we[n_beats]    = mem_we;
                        end
                        if (!mem_we) begin
                            rv_pend = 1'b1;
                            rv_beat = n_beats;
                        end
                        n_beats++;
                    end
                end
            end
            cyc++;
        end while (!done && cyc < 100);
        mem_gnt = 1'b0;
        if (!done) check("access_timeout", 1'b1, 1'b0);
    endtask

    vec_t        tbl[5];
    logic [31:0] exp_a[4];

    initial begin
        tbl[0] = '{1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 32'h0000_0100, {96'h0, 32'hDEAD_BEEF}, 3};
        tbl[1] = '{1'b0, 32'h0000_1237, 32'h0,         32'h1234_5678, 32'h0000_1234, {96'h0, 32'h1234_5678}, 3};
        tbl[2] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         32'h0000_0040, 128'h0,                 2};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'h55AA_55AA, 32'h0,         32'hFFFF_FFFC, 128'h0,                 2};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 32'h0000_0000, {96'h0, 32'hFFFF_FFFF}, 3};

        async_reset = 1'b0; mem_read_M = 1'b0; mem_write_M = 1'b0; vector_op_M = 1'b0;
        ALU_result_bus_M = '0; write_data_bus_M = '0; pipeline_hold = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #3;
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdb", read_data_bus_M, 128'h0);
        check("rst_stall", stall_M, 1'b0);
        repeat (2) @(negedge clock);
        async_reset = 1'b1;

        // Scalar accesses; upper store lanes carry junk that must never reach the port.
        for (int t = 0; t < 5; t++) begin
            do_access(tbl[t].wr, 1'b0, tbl[t].addr,
                      {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, tbl[t].wd},
                      {96'h0, tbl[t].rd}, -1, 0);
            check($sformatf("tbl%0d_beats", t), n_beats, 1);
            check($sformatf("tbl%0d_addr", t), cap_addr[0], tbl[t].exp_addr);
            check($sformatf("tbl%0d_we", t), cap_we[0], tbl[t].wr);
            if (tbl[t].wr) check($sformatf("tbl%0d_wdata", t), cap_wdata[0], tbl[t].wd);
            check($sformatf("tbl%0d_rdb", t), read_data_bus_M, tbl[t].exp_rdb);
            check($sformatf("tbl%0d_stall_cycles", t), n_stall, tbl[t].exp_stall);
            check($sformatf("tbl%0d_done_req", t), mem_req, 1'b0);
            go_idle();
        end

        // Vector store, unaligned base, gnt withheld two cycles on beat 1.
        exp_a = '{32'h200, 32'h204, 32'h208, 32'h20C};
        do_access(1'b1, 1'b1, 32'h0000_0203, {32'h4, 32'h3, 32'h2, 32'h1}, 128'h0, 1, 2);
        check("vst_beats", n_beats, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("vst_addr%0d", i), cap_addr[i], exp_a[i]);
            check($sformatf("vst_wdata%0d", i), cap_wdata[i], 32'(i + 1));
            check($sformatf("vst_we%0d", i), cap_we[i], 1'b1);
        end
        check("vst_stall_cycles", n_stall, 7);
        check("vst_rdb", read_data_bus_M, 128'h0);
        go_idle();

        // Vector load with address wrap past 2^32.
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_access(1'b0, 1'b1, 32'hFFFF_FFF8, 128'h0, {32'hD, 32'hC, 32'hB, 32'hA}, -1, 0);
        check("vld_beats", n_beats, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("vld_addr%0d", i), cap_addr[i], exp_a[i]);
            check($sformatf("vld_we%0d", i), cap_we[i], 1'b0);
        end
        check("vld_rdb", read_data_bus_M, {32'hD, 32'hC, 32'hB, 32'hA});
        check("vld_stall_cycles", n_stall, 9);
        go_idle();

        // DONE held by pipeline_hold with the load still presented: no re-issue.
        do_access(1'b0, 1'b0, 32'h0000_0300, 128'h0, {96'h0, 32'h77}, -1, 0);
        pipeline_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check($sformatf("hold%0d_req", i), mem_req, 1'b0);
            check($sformatf("hold%0d_stall", i), stall_M, 1'b0);
            check($sformatf("hold%0d_rdb", i), read_data_bus_M, {96'h0, 32'h77});
        end
        pipeline_hold    = 1'b0;
        ALU_result_bus_M = {96'h0, 32'h0000_0400};
        @(negedge clock); #1;
        check("hold_exit_idle_stall", stall_M, 1'b1);
        check("hold_exit_idle_req", mem_req, 1'b0);
        @(negedge clock); #1;
        check("hold_next_req", mem_req, 1'b1);
        check("hold_next_addr", mem_addr, 32'h0000_0400);
        mem_gnt = 1'b1;
        @(negedge clock);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        @(negedge clock);
        mem_rvalid = 1'b0;
        #1;
        check("hold_next_stall", stall_M, 1'b0);
        check("hold_next_rdb", read_data_bus_M, {96'h0, 32'h99});
        mem_read_M = 1'b0;

        // Reset pulsed in WAIT_R of a vector load; the late rvalid must be dropped.
        @(negedge clock);
        mem_read_M = 1'b1; vector_op_M = 1'b1; ALU_result_bus_M = {96'h0, 32'h0000_0500};
        @(negedge clock); #1;
        check("rst5_issue_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        @(negedge clock);
        mem_gnt = 1'b0;
        async_reset = 1'b0;
        #1;
        check("rst5_req", mem_req, 1'b0);
        check("rst5_we", mem_we, 1'b0);
        check("rst5_addr", mem_addr, 32'h0);
        check("rst5_wdata", mem_wdata, 32'h0);
        check("rst5_rdb", read_data_bus_M, 128'h0);
        check("rst5_stall", stall_M, 1'b0);
        @(negedge clock);
        async_reset = 1'b1; mem_read_M = 1'b0; vector_op_M = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
        @(negedge clock);
        mem_rvalid = 1'b0;
        #1;
        check("rst5_late_rdb", read_data_bus_M, 128'h0);
        check("rst5_late_req", mem_req, 1'b0);
        check("rst5_late_stall", stall_M, 1'b0);
        exp_a = '{32'h600, 32'h604, 32'h608, 32'h60C};
        do_access(1'b0, 1'b1, 32'h0000_0600, 128'h0, {32'h8, 32'h7, 32'h6, 32'h5}, -1, 0);
        for (int i = 0; i < 4; i++) check($sformatf("rst5_next_addr%0d", i), cap_addr[i], exp_a[i]);
        check("rst5_next_rdb", read_data_bus_M, {32'h8, 32'h7, 32'h6, 32'h5});
        go_idle();

        // Spurious rvalid and gnt while idle.
        @(negedge clock);
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1234;
        #1;
        check("spur_stall", stall_M, 1'b0);
        @(negedge clock);
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        #1;
        check("spur_req", mem_req, 1'b0);
        check("spur_rdb", read_data_bus_M, {32'h8, 32'h7, 32'h6, 32'h5});
        check("spur_stall_after", stall_M, 1'b0);
        do_access(1'b0, 1'b0, 32'h0000_0700, 128'h0, {96'h0, 32'hABCD}, -1, 0);
        check("spur_next_addr", cap_addr[0], 32'h0000_0700);
        check("spur_next_rdb", read_data_bus_M, {96'h0, 32'hABCD});
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
